mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single 16-bit word program/data memory bus between the F100-L CPU (port 0) and the debug/loader port (port 1).
- Serialises requests, drives the memory control strobes, waits a fixed read latency, then returns read data and an ack pulse to the granted requester.
- Sits between the CPU/loader and the memory bus decoder (ROM, RAM, peripherals).

---
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter for the shared 16-bit memory bus
module mem_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [15:0] address0,
  input  logic [15:0] wdata0,
  output logic        ack0,
  output logic [15:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [15:0] address1,
  input  logic [15:0] wdata1,
  output logic        ack1,
  output logic [15:0] rdata1,
  output logic [15:0] mem_address,
  output logic [15:0] mem_write_data,
  output logic        mem_bus_enable,
  output logic        mem_write_enable,
  input  logic [15:0] mem_read_data,
  output logic        grant,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;
  state_t      state_q;
  logic        last_q, grant_q, we_q, en_q, wen_q, ack0_q, ack1_q;
  logic [2:0]  cnt_q;
  logic [15:0] addr_q, wdata_q, rdata0_q, rdata1_q;
  logic        win_d, we_d;
  logic [15:0] addr_d, wdata_d;

  // lone requester wins; on a tie the port not served last time wins
  always_comb begin
    win_d   = req1 & (~req0 | ~last_q);
    we_d    = win_d ? we1 : we0;
    addr_d  = win_d ? address1 : address0;
    wdata_d = win_d ? wdata1 : wdata0;
  end

  // transaction FSM with registered strobes, acks and captured read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      en_q     <= 1'b0;
      wen_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      cnt_q    <= 3'd0;
      addr_q   <= 16'h0;
      wdata_q  <= 16'h0;
      rdata0_q <= 16'h0;
      rdata1_q <= 16'h0;
    end else begin
      case (state_q)
        IDLE: if (req0 | req1) begin
          grant_q <= win_d;
          last_q  <= win_d;
          addr_q  <= addr_d;
          wdata_q <= wdata_d;
          we_q    <= we_d;
          en_q    <= 1'b1;
          wen_q   <= we_d;
          state_q <= ACCESS;
        end
        ACCESS: begin
          en_q    <= 1'b0;
          wen_q   <= 1'b0;
          cnt_q   <= 3'(LATENCY - 1);
          state_q <= WAIT;
        end
        WAIT: if (cnt_q == 3'd0) begin
          if (!we_q && !grant_q) rdata0_q <= mem_read_data;
          if (!we_q && grant_q) rdata1_q <= mem_read_data;
          ack0_q  <= ~grant_q;
          ack1_q  <= grant_q;
          state_q <= ACK;
        end else begin
          cnt_q <= cnt_q - 3'd1;
        end
        ACK: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0             = ack0_q;
  assign ack1             = ack1_q;
  assign rdata0           = rdata0_q;
  assign rdata1           = rdata1_q;
  assign mem_address      = addr_q;
  assign mem_write_data   = wdata_q;
  assign mem_bus_enable   = en_q;
  assign mem_write_enable = wen_q;
  assign grant            = grant_q;
  assign busy             = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, latency, writes and reset abort
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;

  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [15:0] address0 = 0, wdata0 = 0, address1 = 0, wdata1 = 0;
  logic ack0, ack1, en, wen, grant, busy;
  logic [15:0] rdata0, rdata1, ma, mwd, mrd;

  logic b_req0 = 0, b_we0 = 0, b_req1 = 0, b_we1 = 0;
  logic [15:0] b_address0 = 0, b_wdata0 = 0, b_address1 = 0, b_wdata1 = 0;
  logic b_ack0, b_ack1, b_en, b_wen, b_grant, b_busy;
  logic [15:0] b_rdata0, b_rdata1, b_ma, b_mwd, b_mrd;

  logic [2:0] age1, age3;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .address0(address0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .address1(address1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_address(ma), .mem_write_data(mwd), .mem_bus_enable(en), .mem_write_enable(wen),
    .mem_read_data(mrd), .grant(grant), .busy(busy)
  );

  mem_arbiter #(.LATENCY(3)) u3 (
    .clk(clk), .reset(reset),
    .req0(b_req0), .we0(b_we0), .address0(b_address0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
    .req1(b_req1), .we1(b_we1), .address1(b_address1), .wdata1(b_wdata1), .ack1(b_ack1), .rdata1(b_rdata1),
    .mem_address(b_ma), .mem_write_data(b_mwd), .mem_bus_enable(b_en), .mem_write_enable(b_wen),
    .mem_read_data(b_mrd), .grant(b_grant), .busy(b_busy)
  );

  function automatic logic [15:0] lk(input logic [15:0] a);
    return a == 16'h2003 ? 16'hd000 : a ^ 16'h5a5a;
  endfunction

  // memory model: data is valid only LATENCY cycles after the enable cycle
  always @(posedge clk or negedge reset)
    if (!reset) begin
      age1 <= 3'd0;
      age3 <= 3'd0;
    end else begin
      age1 <= en ? 3'd1 : (age1 != 3'd0 && age1 != 3'd7) ? age1 + 3'd1 : age1;
      age3 <= b_en ? 3'd1 : (age3 != 3'd0 && age3 != 3'd7) ? age3 + 3'd1 : age3;
    end

  assign mrd   = age1 == 3'd1 ? lk(ma) : 16'hdead;
  assign b_mrd = age3 == 3'd3 ? lk(b_ma) : 16'hdead;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_ack", {14'h0, ack1, ack0}, 16'h0);
    check("rst_strobes", {14'h0, wen, en}, 16'h0);
    check("rst_grant", 16'(grant), 16'h0);
    check("rst_addr", ma, 16'h0);
    check("rst_rdata0", rdata0, 16'h0);
    reset = 1'b1;
    step();

    req0 = 1; we0 = 0; address0 = 16'h2003;
    check("rd0_idle_busy", 16'(busy), 16'h0);
    step();
    check("rd0_en", {14'h0, wen, en}, 16'h1);
    check("rd0_addr", ma, 16'h2003);
    check("rd0_grant", 16'(grant), 16'h0);
    check("rd0_busy", 16'(busy), 16'h1);
    step();
    check("rd0_wait", {13'h0, ack1, ack0, en}, 16'h0);
    step();
    check("rd0_ack", {14'h0, ack1, ack0}, 16'h1);
    check("rd0_rdata", rdata0, 16'hd000);
    step();
    req0 = 0;
    check("rd0_done", {13'h0, busy, ack1, ack0}, 16'h0);

    req1 = 1; we1 = 1; address1 = 16'h4008; wdata1 = 16'h0001;
    step();
    check("wr1_strobes", {14'h0, wen, en}, 16'h3);
    check("wr1_addr", ma, 16'h4008);
    check("wr1_wdata", mwd, 16'h0001);
    check("wr1_grant", 16'(grant), 16'h1);
    step();
    check("wr1_wait", {14'h0, wen, en}, 16'h0);
    step();
    check("wr1_ack", {14'h0, ack1, ack0}, 16'h2);
    check("wr1_rdata", rdata1, 16'h0000);
    step();
    req1 = 0; we1 = 0;
    check("wr1_done", {14'h0, ack1, ack0}, 16'h0);

    req0 = 1; address0 = 16'h0010;
    step();
    req1 = 1; address1 = 16'h0020;
    check("mid_grant0", 16'(grant), 16'h0);
    step();
    step();
    check("mid_ack0", {14'h0, ack1, ack0}, 16'h1);
    check("mid_rdata0", rdata0, 16'h5a4a);
    step();
    req0 = 0;
    check("mid_idle", {14'h0, busy, en}, 16'h0);
    step();
    check("mid_en1", 16'(en), 16'h1);
    check("mid_grant1", 16'(grant), 16'h1);
    check("mid_addr1", ma, 16'h0020);
    step();
    step();
    check("mid_ack1", {14'h0, ack1, ack0}, 16'h2);
    check("mid_rdata1", rdata1, 16'h5a7a);
    check("mid_rdata0_hold", rdata0, 16'h5a4a);
    step();
    req1 = 0;

    req1 = 1; address1 = 16'h0030;
    step();
    check("abt_en", 16'(en), 16'h1);
    check("abt_grant", 16'(grant), 16'h1);
    step();
    check("abt_wait_busy", 16'(busy), 16'h1);
    #1 reset = 1'b0;
    #1;
    check("abt_drop", {13'h0, busy, ack1, en}, 16'h0);
    check("abt_rdata1", rdata1, 16'h0);
    req1 = 0;
    step();
    check("abt_no_ack", {14'h0, ack1, ack0}, 16'h0);
    reset = 1'b1;

    req0 = 1; address0 = 16'h0100;
    req1 = 1; address1 = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rr%0d_en", k), 16'(en), 16'h1);
      check($sformatf("rr%0d_grant", k), 16'(grant), 16'(k % 2));
      check($sformatf("rr%0d_addr", k), ma, (k % 2) ? 16'h0200 : 16'h0100);
      step();
      check($sformatf("rr%0d_wait", k), {13'h0, ack1, ack0, en}, 16'h0);
      step();
      check($sformatf("rr%0d_ack", k), {14'h0, ack1, ack0}, (k % 2) ? 16'h2 : 16'h1);
      check($sformatf("rr%0d_rdata", k), (k % 2) ? rdata1 : rdata0, (k % 2) ? 16'h585a : 16'h5b5a);
      step();
      if (k == 3) begin
        req0 = 0;
        req1 = 0;
      end
      check($sformatf("rr%0d_idle", k), {13'h0, ack1, ack0, en}, 16'h0);
    end
    step();
    check("rr_quiet", {13'h0, busy, ack1, en}, 16'h0);

    b_req0 = 1; b_address0 = 16'h2003;
    step();
    check("l3_en", 16'(b_en), 16'h1);
    check("l3_addr", b_ma, 16'h2003);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("l3_wait%0d", i), {12'h0, b_busy, b_ack1, b_ack0, b_en}, 16'h8);
    end
    step();
    check("l3_ack", {14'h0, b_ack1, b_ack0}, 16'h1);
    check("l3_rdata", b_rdata0, 16'hd000);
    step();
    b_req0 = 0;
    check("l3_done", {13'h0, b_busy, b_ack1, b_ack0}, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
